// File: rtl/ct_fcnvt_narrow_sh_pipe_if.sv
// Handshake and data bundle for the narrowing-convert denormal shift/round pipe.
// master = upstream/downstream environment, slave = the pipe itself.
interface ct_fcnvt_narrow_sh_pipe_if #(
    parameter int SRC_EXP_W  = 11,
    parameter int SRC_FRAC_W = 52,
    parameter int DST_FRAC_W = 23,
    parameter int TAG_W      = 8
);
    localparam int V_W = DST_FRAC_W + 1;

    logic                  sh_in_vld;
    logic                  sh_in_rdy;
    logic [SRC_EXP_W-1:0]  sh_in_cnt;
    logic [SRC_FRAC_W-1:0] sh_in_src;
    logic                  sh_in_sign;
    logic [2:0]            sh_in_rm;
    logic [TAG_W-1:0]      sh_in_tag;

    logic                  sh_out_vld;
    logic                  sh_out_rdy;
    logic [V_W-1:0]        sh_out_f_v;
    logic [DST_FRAC_W-1:0] sh_out_frac;
    logic                  sh_out_to_norm;
    logic                  sh_out_inexact;
    logic                  sh_out_denorm;
    logic [TAG_W-1:0]      sh_out_tag;

    modport master (
        output sh_in_vld, sh_in_cnt, sh_in_src, sh_in_sign, sh_in_rm, sh_in_tag, sh_out_rdy,
        input  sh_in_rdy, sh_out_vld, sh_out_f_v, sh_out_frac, sh_out_to_norm,
               sh_out_inexact, sh_out_denorm, sh_out_tag
    );

    modport slave (
        input  sh_in_vld, sh_in_cnt, sh_in_src, sh_in_sign, sh_in_rm, sh_in_tag, sh_out_rdy,
        output sh_in_rdy, sh_out_vld, sh_out_f_v, sh_out_frac, sh_out_to_norm,
               sh_out_inexact, sh_out_denorm, sh_out_tag
    );
endinterface

// File: rtl/ct_fcnvt_narrow_sh_pipe.sv
// Two-stage denormal align (S1) and round (S2) for narrowing FP converts.
// valid/ready on both ends, flush kills both stages, outputs driven from S2 flops.
module ct_fcnvt_narrow_sh_pipe #(
    parameter int SRC_EXP_W  = 11,
    parameter int SRC_FRAC_W = 52,
    parameter int DST_EXP_W  = 8,
    parameter int DST_FRAC_W = 23,
    parameter int TAG_W      = 8
) (
    input logic                      forever_cpuclk,
    input logic                      cpurst,
    input logic                      pipe_flush,
    ct_fcnvt_narrow_sh_pipe_if.slave sh
);
    localparam int STAGES = 2;
    localparam int V_W    = DST_FRAC_W + 1;
    localparam int X_W    = SRC_FRAC_W + 2;
    localparam int AL_W   = V_W + X_W;
    localparam int TOP    = (2**(SRC_EXP_W-1) - 1) - (2**(DST_EXP_W-1) - 1);
    localparam int E_W    = SRC_EXP_W + 1;

    localparam logic [E_W-1:0]  TOP_E = E_W'(TOP);
    localparam logic [E_W-1:0]  KMAX  = E_W'(V_W);
    localparam logic [E_W-1:0]  ONE_E = E_W'(1);
    localparam logic [X_W-1:0]  X_STK = {2'b00, 1'b1, {(X_W-3){1'b0}}};

    logic [STAGES:1]       vld_pipe;
    logic                  s2_adv, s1_adv, in_acc;

    // S1 state
    logic [V_W-1:0]        s1_v;
    logic [X_W-1:0]        s1_x;
    logic                  s1_sign, s1_den;
    logic [2:0]            s1_rm;
    logic [TAG_W-1:0]      s1_tag;

    // S2 state
    logic [V_W-1:0]        s2_fv;
    logic [DST_FRAC_W-1:0] s2_frac;
    logic                  s2_norm, s2_inx, s2_den;
    logic [TAG_W-1:0]      s2_tag;

    assign s2_adv       = ~vld_pipe[2] | sh.sh_out_rdy;
    assign s1_adv       = vld_pipe[1] & s2_adv;
    assign sh.sh_in_rdy = ~pipe_flush & (~vld_pipe[1] | s2_adv);
    assign in_acc       = sh.sh_in_vld & sh.sh_in_rdy;

    // Align: k = TOP - cnt, computed one bit wider so cnt > TOP is visible.
    logic [E_W-1:0]  cnt_e, k, shamt;
    logic [AL_W-1:0] al, al_sh;
    logic            in_den;
    logic [V_W-1:0]  a_v;
    logic [X_W-1:0]  a_x;

    always_comb begin
        cnt_e  = {1'b0, sh.sh_in_cnt};
        in_den = (cnt_e <= TOP_E);
        k      = TOP_E - cnt_e;
        shamt  = k + ONE_E;
        al     = {1'b1, sh.sh_in_src, {(AL_W-1-SRC_FRAC_W){1'b0}}};
        al_sh  = al >> shamt;
        a_v    = '0;
        a_x    = '0;
        if (in_den) begin
            if (k <= KMAX) {a_v, a_x} = al_sh;
            else           a_x = X_STK;
        end
    end

    // Round on the S1 registers.
    logic           g, st, incr;
    logic [V_W-1:0] sum;

    always_comb begin
        g  = s1_x[X_W-1];
        st = |s1_x[X_W-2:0];
        case (s1_rm)
            3'd1:    incr = 1'b0;
            3'd2:    incr = s1_sign & (g | st);
            3'd3:    incr = ~s1_sign & (g | st);
            3'd4:    incr = g;
            default: incr = g & (st | s1_v[0]);
        endcase
        sum = s1_v + {{(V_W-1){1'b0}}, incr};
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            vld_pipe <= '0;
            s1_v     <= '0;
            s1_x     <= '0;
            s1_sign  <= 1'b0;
            s1_den   <= 1'b0;
            s1_rm    <= '0;
            s1_tag   <= '0;
            s2_fv    <= '0;
            s2_frac  <= '0;
            s2_norm  <= 1'b0;
            s2_inx   <= 1'b0;
            s2_den   <= 1'b0;
            s2_tag   <= '0;
        end else begin
            if (pipe_flush) begin
                vld_pipe <= '0;
            end else begin
                if (in_acc)      vld_pipe[1] <= 1'b1;
                else if (s1_adv) vld_pipe[1] <= 1'b0;
                if (s2_adv)      vld_pipe[2] <= vld_pipe[1];
            end
            if (in_acc) begin
                s1_v    <= a_v;
                s1_x    <= a_x;
                s1_sign <= sh.sh_in_sign;
                s1_den  <= in_den;
                s1_rm   <= sh.sh_in_rm;
                s1_tag  <= sh.sh_in_tag;
            end
            // S2 only loads on advance, so its contents hold through a stall.
            if (s1_adv) begin
                s2_fv   <= s1_v;
                s2_frac <= sum[DST_FRAC_W-1:0];
                s2_norm <= sum[DST_FRAC_W];
                s2_inx  <= g | st;
                s2_den  <= s1_den;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign sh.sh_out_vld     = vld_pipe[2];
    assign sh.sh_out_f_v     = s2_fv;
    assign sh.sh_out_frac    = s2_frac;
    assign sh.sh_out_to_norm = s2_norm;
    assign sh.sh_out_inexact = s2_inx;
    assign sh.sh_out_denorm  = s2_den;
    assign sh.sh_out_tag     = s2_tag;
endmodule
